// File: rtl/efuse_pkg.sv
// Shared types and timing helpers for the parametrised SISO eFuse controller.
package efuse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_BIT_HI,
    ST_BIT_LO,
    ST_HOLD,
    ST_VERIFY_RD,
    ST_DONE
  } efuse_st_t;

  typedef enum logic {
    RD = 1'b0,
    PG = 1'b1
  } efuse_mode_t;

  // Cycles from read_ack to dout_valid for a full read pass.
  function automatic int rd_cycles(input int data_w, input int sclk_div);
    return sclk_div * (2 + 2 * data_w) + 1;
  endfunction

endpackage

// File: rtl/efuse_phase_timer.sv
// Down-counting phase timer: i_start loads a length, o_expire marks the last cycle of it.
module efuse_phase_timer #(
  parameter int CW = 14
) (
  input  logic          clk_osc,
  input  logic          rst,
  input  logic          i_start,
  input  logic [CW-1:0] i_load,
  output logic          o_expire
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_osc) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= i_load - CW'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // i_start is high in the first cycle of a phase, so a length of 1 expires immediately.
  assign o_expire = i_start ? (i_load == CW'(1)) : (r_cnt == CW'(1));

endmodule

// File: rtl/efuse_ctrl_param.sv
// SISO eFuse controller: serial read, program of '1' bits only, optional read-back verify.
module efuse_ctrl_param
  import efuse_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SCLK_DIV  = 16,
  parameter int PGM_CYC   = 8192,
  parameter int VERIFY_EN = 1
) (
  input  logic              clk_osc,
  input  logic              rst,
  input  logic              read_start,
  output logic              read_ack,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              prog_start,
  input  logic [DATA_W-1:0] prog_din,
  output logic              prog_ack,
  output logic              prog_done,
  output logic              prog_err,
  output logic              busy,
  output logic              EFUSE_CS,
  output logic              EFUSE_PGM,
  output logic              EFUSE_SCLK,
  output logic              EFUSE_RW,
  input  logic              EFUSE_DOUT,
  output logic [2:0]        dbg_state
);

  localparam int CW = $clog2(PGM_CYC + 1);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] L_DIV  = CW'(SCLK_DIV);
  localparam logic [CW-1:0] L_PGM  = CW'(PGM_CYC);
  localparam logic [IW-1:0] L_LAST = IW'(DATA_W - 1);

  efuse_st_t         r_st;
  efuse_mode_t       r_mode;
  logic              r_verify;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_din, r_shift, r_dout;
  logic              r_tmr_start;
  logic [CW-1:0]     r_tmr_load;
  logic              r_read_ack, r_dout_valid, r_prog_ack, r_prog_done, r_prog_err, r_busy;
  logic              r_cs, r_pgm, r_sclk, r_rw;

  logic              w_expire;
  logic [DATA_W-1:0] w_din;
  logic [IW-1:0]     w_idx_nxt, w_hi_idx;
  logic              w_hi_pgm;

  efuse_phase_timer #(.CW(CW)) u_timer (
    .clk_osc  (clk_osc),
    .rst      (rst),
    .i_start  (r_tmr_start),
    .i_load   (r_tmr_load),
    .o_expire (w_expire)
  );

  // prog_din is captured at the end of the ack cycle; bypass it for a 1-cycle SETUP.
  assign w_din     = r_prog_ack ? prog_din : r_din;
  assign w_idx_nxt = r_idx + IW'(1);
  assign w_hi_idx  = (r_st == ST_BIT_LO) ? w_idx_nxt : r_idx;
  assign w_hi_pgm  = (r_mode == PG) && w_din[w_hi_idx];

  // Requests are levels held by the requester; the controller answers with a
  // one-cycle ack only from IDLE, and prog wins when both are present.
  always_ff @(posedge clk_osc) begin
    if (rst) begin
      r_st <= ST_IDLE;  r_mode <= RD;  r_verify <= 1'b0;  r_idx <= '0;
      r_din <= '0;  r_shift <= '0;  r_dout <= '0;
      r_tmr_start <= 1'b0;  r_tmr_load <= '0;
      r_read_ack <= 1'b0;  r_dout_valid <= 1'b0;  r_prog_ack <= 1'b0;
      r_prog_done <= 1'b0;  r_prog_err <= 1'b0;  r_busy <= 1'b0;
      r_cs <= 1'b0;  r_pgm <= 1'b0;  r_sclk <= 1'b0;  r_rw <= 1'b0;
    end else begin
      r_read_ack   <= 1'b0;
      r_prog_ack   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_prog_done  <= 1'b0;
      r_tmr_start  <= 1'b0;
      if (r_prog_ack) r_din <= prog_din;
      case (r_st)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (prog_start || read_start) begin
            r_busy      <= 1'b1;
            r_cs        <= 1'b1;
            r_sclk      <= 1'b0;
            r_idx       <= '0;
            r_verify    <= 1'b0;
            r_tmr_start <= 1'b1;
            r_tmr_load  <= L_DIV;
            r_st        <= ST_SETUP;
            if (prog_start) begin
              r_prog_ack <= 1'b1;
              r_prog_err <= 1'b0;
              r_mode     <= PG;
              r_rw       <= 1'b1;
            end else begin
              r_read_ack <= 1'b1;
              r_mode     <= RD;
              r_rw       <= 1'b0;
            end
          end
        end
        ST_SETUP, ST_BIT_LO: begin
          if (w_expire) begin
            r_tmr_start <= 1'b1;
            if (r_st == ST_BIT_LO && r_idx == L_LAST) begin
              r_tmr_load <= L_DIV;
              r_st       <= ST_HOLD;
            end else begin
              if (r_st == ST_BIT_LO) r_idx <= w_idx_nxt;
              r_sclk     <= 1'b1;
              r_pgm      <= w_hi_pgm;
              r_tmr_load <= w_hi_pgm ? L_PGM : L_DIV;
              r_st       <= ST_BIT_HI;
            end
          end
        end
        ST_BIT_HI: begin
          if (w_expire) begin
            r_sclk      <= 1'b0;
            r_pgm       <= 1'b0;
            if (r_mode == RD) r_shift[r_idx] <= EFUSE_DOUT;
            r_tmr_start <= 1'b1;
            r_tmr_load  <= L_DIV;
            r_st        <= ST_BIT_LO;
          end
        end
        ST_HOLD: begin
          if (w_expire) begin
            r_cs <= 1'b0;
            r_rw <= 1'b0;
            r_st <= (r_mode == PG && VERIFY_EN != 0) ? ST_VERIFY_RD : ST_DONE;
          end
        end
        ST_VERIFY_RD: begin
          // CS-low gap cycle, then an internal read pass with identical timing.
          r_verify    <= 1'b1;
          r_mode      <= RD;
          r_cs        <= 1'b1;
          r_rw        <= 1'b0;
          r_idx       <= '0;
          r_tmr_start <= 1'b1;
          r_tmr_load  <= L_DIV;
          r_st        <= ST_SETUP;
        end
        ST_DONE: begin
          r_st <= ST_IDLE;
          if (r_verify) begin
            r_prog_done <= 1'b1;
            r_prog_err  <= (r_shift & r_din) != r_din;
          end else if (r_mode == PG) begin
            r_prog_done <= 1'b1;
            r_prog_err  <= 1'b0;
          end else begin
            r_dout       <= r_shift;
            r_dout_valid <= 1'b1;
          end
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  assign read_ack   = r_read_ack;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign prog_ack   = r_prog_ack;
  assign prog_done  = r_prog_done;
  assign prog_err   = r_prog_err;
  assign busy       = r_busy;
  assign EFUSE_CS   = r_cs;
  assign EFUSE_PGM  = r_pgm;
  assign EFUSE_SCLK = r_sclk;
  assign EFUSE_RW   = r_rw;
  assign dbg_state  = r_st;

endmodule
